// File: rtl/decoder_3to8_hold_pkg.sv
// Shared constants and state type for the 3-to-8 hold decoder.
// Imported by the interface, the one-hot decode leaf and the top.
package decoder_pkg;

    localparam int CODE_W  = 3;
    localparam int NUM_SEL = 8;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_3to8_hold_if.sv
// Handshake input and select-line outputs of the 3-to-8 hold decoder.
// The master side offers codes; the slave side is the decoder itself.
interface decoder_3to8_hold_if;
    import decoder_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [CODE_W-1:0]  in_code;
    logic [NUM_SEL-1:0] out_sel;
    logic               out_active;
    logic               busy;
    logic               done;

    modport master (
        output in_valid, in_code,
        input  in_ready, out_sel, out_active, busy, done
    );

    modport slave (
        input  in_valid, in_code,
        output in_ready, out_sel, out_active, busy, done
    );

endinterface

// File: rtl/decoder_3to8_hold_onehot_dec3.sv
// Purely combinational binary-to-one-hot decode of a 3-bit code.
// Exactly one output bit is set for every input value.
module onehot_dec3
    import decoder_pkg::*;
(
    input  logic [CODE_W-1:0]  code,
    output logic [NUM_SEL-1:0] sel
);

    always_comb begin
        sel       = '0;
        sel[code] = 1'b1;
    end

endmodule

// File: rtl/decoder_3to8_hold.sv
// Sequential 3-to-8 decoder: holds each select for HOLD_CYCLES, then a
// GAP_CYCLES break, with a one-entry pending buffer for the next code.
module decoder_3to8_hold
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    decoder_3to8_hold_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [CODE_W-1:0]  cur_code, cur_code_d;
    logic [CODE_W-1:0]  pend_code, pend_code_d;
    logic               pend_full, pend_full_d;
    logic [NUM_SEL-1:0] dec_sel;
    logic [NUM_SEL-1:0] out_sel_q;
    logic               in_ready_q, out_active_q, busy_q, done_q;
    logic               xfer;

    assign xfer = bus.in_valid && in_ready_q;

    // Decoding the next code lets out_sel be registered in step with the state.
    onehot_dec3 u_dec (
        .code (cur_code_d),
        .sel  (dec_sel)
    );

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        cur_code_d  = cur_code;
        pend_code_d = pend_code;
        pend_full_d = pend_full;

        unique case (state)
            IDLE: begin
                if (pend_full) begin
                    state_d     = HOLD;
                    cur_code_d  = pend_code;
                    pend_full_d = 1'b0;
                    cnt_d       = HOLD_LOAD;
                end else if (xfer) begin
                    state_d    = HOLD;
                    cur_code_d = bus.in_code;
                    cnt_d      = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (xfer) begin
                    pend_full_d = 1'b1;
                    pend_code_d = bus.in_code;
                end
                if (cnt == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else if (pend_full) begin
                        state_d     = HOLD;
                        cur_code_d  = pend_code;
                        pend_full_d = 1'b0;
                        cnt_d       = HOLD_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (xfer) begin
                    pend_full_d = 1'b1;
                    pend_code_d = bus.in_code;
                end
                if (cnt == '0) begin
                    if (pend_full) begin
                        state_d     = HOLD;
                        cur_code_d  = pend_code;
                        pend_full_d = 1'b0;
                        cnt_d       = HOLD_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            cur_code     <= '0;
            pend_code    <= '0;
            pend_full    <= 1'b0;
            out_sel_q    <= '0;
            in_ready_q   <= 1'b0;
            out_active_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            cur_code     <= cur_code_d;
            pend_code    <= pend_code_d;
            pend_full    <= pend_full_d;
            out_sel_q    <= (state_d == HOLD) ? dec_sel : '0;
            in_ready_q   <= !pend_full_d;
            out_active_q <= (state_d == HOLD);
            busy_q       <= (state_d != IDLE) || pend_full_d;
            done_q       <= (state_d == HOLD) && (cnt_d == '0);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_sel    = out_sel_q;
    assign bus.out_active = out_active_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_decoder_3to8_hold.sv
// Drives two decoder instances (HOLD=4/GAP=1 and HOLD=2/GAP=0) with shared stimulus
// and compares every output against a schedule-based reference model.
module tb_decoder_3to8_hold;
    import decoder_pkg::*;

    localparam int HOLD_A = 4;
    localparam int GAP_A  = 1;
    localparam int HOLD_B = 2;
    localparam int GAP_B  = 0;
    localparam int MAXE   = 512;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    decoder_3to8_hold_if a_if ();
    decoder_3to8_hold_if b_if ();

    decoder_3to8_hold #(.HOLD_CYCLES(HOLD_A), .GAP_CYCLES(GAP_A)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    decoder_3to8_hold #(.HOLD_CYCLES(HOLD_B), .GAP_CYCLES(GAP_B)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         st [2][MAXE];
    int         ac [2][MAXE];
    logic [2:0] cd [2][MAXE];
    int         n_ent [2];
    logic [7:0] watch_sel [2];
    int         hits [2];

    // Model: each accepted code gets a start edge; outputs follow from start windows.
    function automatic int holdOf(input int d);
        return (d == 0) ? HOLD_A : HOLD_B;
    endfunction

    function automatic int gapOf(input int d);
        return (d == 0) ? GAP_A : GAP_B;
    endfunction

    function automatic int firstRecent(input int d);
        return (n_ent[d] > 4) ? n_ent[d] - 4 : 0;
    endfunction

    function automatic logic modelWaiting(input int d, input int k);
        int i;
        if (n_ent[d] == 0) return 1'b0;
        i = n_ent[d] - 1;
        return (ac[d][i] <= k) && (k < st[d][i]);
    endfunction

    function automatic logic [7:0] modelSel(input int d, input int k);
        logic [7:0] s;
        s = 8'h00;
        for (int i = firstRecent(d); i < n_ent[d]; i++)
            if (k >= st[d][i] && k < st[d][i] + holdOf(d)) s = 8'h01 << cd[d][i];
        return s;
    endfunction

    function automatic logic modelDone(input int d, input int k);
        logic r;
        r = 1'b0;
        for (int i = firstRecent(d); i < n_ent[d]; i++)
            if (k == st[d][i] + holdOf(d) - 1) r = 1'b1;
        return r;
    endfunction

    function automatic logic modelBusy(input int d, input int k);
        logic r;
        r = modelWaiting(d, k);
        for (int i = firstRecent(d); i < n_ent[d]; i++)
            if (k >= st[d][i] && k < st[d][i] + holdOf(d) + gapOf(d)) r = 1'b1;
        return r;
    endfunction

    function automatic void modelAccept(input int d, input int t, input logic [2:0] c);
        int s;
        int e;
        s = t;
        if (n_ent[d] > 0) begin
            e = st[d][n_ent[d]-1] + holdOf(d) + gapOf(d);
            if (t < e) s = e;
            else if (t == e) s = e + 1;
        end
        if (n_ent[d] < MAXE) begin
            st[d][n_ent[d]] = s;
            ac[d][n_ent[d]] = t;
            cd[d][n_ent[d]] = c;
            n_ent[d]++;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic checkDut(input int d, input logic [7:0] sel, input logic act,
                            input logic rdy, input logic bsy, input logic dn);
        logic [7:0] esel;
        esel = modelSel(d, cyc);
        checkOutput($sformatf("dut%0d out_sel", d), 32'(sel), 32'(esel));
        checkOutput($sformatf("dut%0d out_active", d), 32'(act), 32'(esel != 8'h00));
        checkOutput($sformatf("dut%0d in_ready", d), 32'(rdy), 32'(!modelWaiting(d, cyc)));
        checkOutput($sformatf("dut%0d busy", d), 32'(bsy), 32'(modelBusy(d, cyc)));
        checkOutput($sformatf("dut%0d done", d), 32'(dn), 32'(modelDone(d, cyc)));
        checkOutput($sformatf("dut%0d onehot", d), 32'($countones(sel) <= 1), 32'(1));
        checkOutput($sformatf("dut%0d active_vs_sel", d), 32'(act), 32'(|sel));
        if (sel == watch_sel[d]) hits[d]++;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] c);
        for (int d = 0; d < 2; d++)
            if (v && !modelWaiting(d, cyc)) modelAccept(d, cyc + 1, c);
        a_if.in_valid = v;
        a_if.in_code  = c;
        b_if.in_valid = v;
        b_if.in_code  = c;
        @(posedge clk);
        #1;
        cyc++;
        checkDut(0, a_if.out_sel, a_if.out_active, a_if.in_ready, a_if.busy, a_if.done);
        checkDut(1, b_if.out_sel, b_if.out_active, b_if.in_ready, b_if.busy, b_if.done);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0);
    endtask

    // Presents one code until instance d accepts it, with a bounded wait.
    task automatic offerCode(input int d, input logic [2:0] c);
        int guard;
        logic taken;
        guard = 0;
        taken = 1'b0;
        while (!taken && guard < 50) begin
            taken = !modelWaiting(d, cyc);
            applyStimulus(1'b1, c);
            guard++;
        end
        if (!taken) checkOutput("offer_timeout", 32'(0), 32'(1));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " a out_sel"},  32'(a_if.out_sel), 32'(0));
        checkOutput({tag, " b out_sel"},  32'(b_if.out_sel), 32'(0));
        checkOutput({tag, " a in_ready"}, 32'(a_if.in_ready), 32'(0));
        checkOutput({tag, " a busy"},     32'(a_if.busy), 32'(0));
        checkOutput({tag, " a done"},     32'(a_if.done), 32'(0));
        checkOutput({tag, " b active"},   32'(b_if.out_active), 32'(0));
    endtask

    task automatic doReset();
        a_if.in_valid = 1'b0;
        a_if.in_code  = 3'd0;
        b_if.in_valid = 1'b0;
        b_if.in_code  = 3'd0;
        rst_n = 1'b0;
        #1;
        checkReset("rst_now");
        repeat (2) @(posedge clk);
        #1;
        checkReset("rst_held");
        @(negedge clk);
        rst_n    = 1'b1;
        cyc      = 0;
        n_ent[0] = 0;
        n_ent[1] = 0;
        idleCycles(2);
    endtask

    initial begin
        watch_sel[0] = 8'hFF;
        watch_sel[1] = 8'hFF;
        hits[0] = 0;
        hits[1] = 0;
        n_ent[0] = 0;
        n_ent[1] = 0;
        a_if.in_valid = 1'b0;
        a_if.in_code  = 3'd0;
        b_if.in_valid = 1'b0;
        b_if.in_code  = 3'd0;
        #2;
        doReset();

        $display("[TB] single code");
        watch_sel[0] = 8'h20;
        hits[0] = 0;
        applyStimulus(1'b1, 3'd5);
        idleCycles(8);
        checkOutput("single hold length", 32'(hits[0]), 32'(HOLD_A));

        $display("[TB] back-to-back");
        applyStimulus(1'b1, 3'd0);
        applyStimulus(1'b0, 3'd0);
        applyStimulus(1'b1, 3'd7);
        idleCycles(12);

        $display("[TB] backpressure");
        offerCode(0, 3'd1);
        offerCode(0, 3'd2);
        offerCode(0, 3'd4);
        idleCycles(14);

        $display("[TB] zero gap");
        watch_sel[1] = 8'h04;
        hits[1] = 0;
        offerCode(1, 3'd2);
        offerCode(1, 3'd2);
        offerCode(1, 3'd6);
        idleCycles(8);
        checkOutput("zero gap repeated hold", 32'(hits[1]), 32'(2 * HOLD_B));

        $display("[TB] random soak");
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
        idleCycles(12);

        $display("[TB] reset mid-hold");
        applyStimulus(1'b1, 3'd1);
        applyStimulus(1'b1, 3'd3);
        a_if.in_valid = 1'b0;
        b_if.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset a out_sel", 32'(a_if.out_sel), 32'(0));
        checkOutput("async reset a done", 32'(a_if.done), 32'(0));
        watch_sel[0] = 8'h08;
        hits[0] = 0;
        doReset();
        checkOutput("ready after reset", 32'(a_if.in_ready), 32'(1));
        idleCycles(10);
        checkOutput("pending code discarded", 32'(hits[0]), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
